vx_core_mem_arb: RTL and testbench

VX_CORE_MEM_ARB -- requirements
Module: VX_core_mem_arb

---
 rtl/vx_core_mem_arb_if.sv | 47 ++++
 rtl/vx_core_mem_arb.sv | 180 ++++++++++++++++++
 tb/tb_vx_core_mem_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_core_mem_arb_if.sv
// ----------------------------------------------------------------------------
// vx_core_mem_arb_if
// Request/response bus bundle used on both sides of the memory arbiter.
//   N lanes of request (valid/rw/addr/data/byteen/tag/ready) travelling from
//   master to slave, and a response (per-lane valid/ready, shared data/tag)
//   travelling from slave to master.
//   Core side: N = NUM_REQS, TAG_WIDTH = input tag width.
//   Memory side: N = 1, TAG_WIDTH = input tag width + clog2(NUM_REQS).
// Modports:
//   master - issues requests, accepts responses
//   slave  - accepts requests, issues responses
// ----------------------------------------------------------------------------
interface vx_core_mem_arb_if #(
  parameter int unsigned N          = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
);
  localparam int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8;

  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_rw;
  logic [N*ADDR_WIDTH-1:0]   req_addr;
  logic [N*DATA_WIDTH-1:0]   req_data;
  logic [N*BYTEEN_WIDTH-1:0] req_byteen;
  logic [N*TAG_WIDTH-1:0]    req_tag;
  logic [N-1:0]              req_ready;

  logic [N-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic [TAG_WIDTH-1:0]      rsp_tag;
  logic [N-1:0]              rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/vx_core_mem_arb.sv
// ----------------------------------------------------------------------------
// vx_core_mem_arb
// Merges NUM_REQS core request ports onto one memory request port with a
// round-robin arbiter and a 2-entry output buffer; routes memory responses
// back to the originating port using the port index carried in the tag MSBs.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   core_bus     - slave side, NUM_REQS lanes, TAG_WIDTH tags
//   mem_bus      - master side, 1 lane, TAG_WIDTH + clog2(NUM_REQS) tags
//   perf_stalls  - (MEM_ARB_PERF_EN only) cycles with a pending but unfired request
//   perf_reqs    - (MEM_ARB_PERF_EN only) memory request handshakes
// Optional feature macro: MEM_ARB_PERF_EN adds the two 44-bit perf counters.
// ----------------------------------------------------------------------------
module vx_core_mem_arb #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  vx_core_mem_arb_if.slave   core_bus,
  vx_core_mem_arb_if.master  mem_bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [43:0]        perf_stalls,
  output logic [43:0]        perf_reqs
`endif
);

  localparam int unsigned IDX_WIDTH    = $clog2(NUM_REQS);
  localparam int unsigned SCAN_WIDTH   = IDX_WIDTH + 1;
  localparam int unsigned OTW          = TAG_WIDTH + IDX_WIDTH;
  localparam int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + BYTEEN_WIDTH + OTW;

  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   grant_idx;
  logic                   grant_found;
  logic [SCAN_WIDTH-1:0]  scan_sum;
  logic [SCAN_WIDTH-1:0]  ptr_inc;

  logic [ENTRY_WIDTH-1:0] buf_q [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [ENTRY_WIDTH-1:0] push_entry;
  logic [ENTRY_WIDTH-1:0] head_entry;

  logic [IDX_WIDTH-1:0]   rsp_idx;

  // Round-robin scan: first valid lane at or after ptr_q, modulo NUM_REQS
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      scan_sum = SCAN_WIDTH'(ptr_q) + SCAN_WIDTH'(k);
      if (scan_sum >= SCAN_WIDTH'(NUM_REQS)) begin
        scan_sum = scan_sum - SCAN_WIDTH'(NUM_REQS);
      end
      if (!grant_found && core_bus.req_valid[scan_sum[IDX_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[IDX_WIDTH-1:0];
      end
    end
  end

  assign full = (count_q == 2'd2);
  // Reset gating keeps req_ready low during the reset cycle itself
  assign push = grant_found && !full && !reset;
  assign pop  = (count_q != 2'd0) && mem_bus.req_ready[0];

  // Only the granted lane sees ready
  always_comb begin
    core_bus.req_ready = '0;
    if (push) begin
      core_bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Granted lane payload with the lane index prepended to its tag
  assign push_entry = {
    core_bus.req_rw[grant_idx],
    core_bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH],
    core_bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH],
    core_bus.req_byteen[grant_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH],
    grant_idx,
    core_bus.req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH]
  };

  // Next-state for pointer and buffer bookkeeping
  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ptr_inc  = SCAN_WIDTH'(grant_idx) + SCAN_WIDTH'(1);
    if (push) begin
      ptr_d    = (ptr_inc == SCAN_WIDTH'(NUM_REQS)) ? '0 : ptr_inc[IDX_WIDTH-1:0];
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry        = buf_q[rd_ptr_q];
  assign mem_bus.req_valid = (count_q != 2'd0);
  assign {mem_bus.req_rw, mem_bus.req_addr, mem_bus.req_data,
          mem_bus.req_byteen, mem_bus.req_tag} = head_entry;

  // Response demux; out-of-range lane indices are accepted and dropped
  assign rsp_idx           = mem_bus.rsp_tag[OTW-1 -: IDX_WIDTH];
  assign core_bus.rsp_data = mem_bus.rsp_data;
  assign core_bus.rsp_tag  = mem_bus.rsp_tag[TAG_WIDTH-1:0];

  always_comb begin
    core_bus.rsp_valid = '0;
    mem_bus.rsp_ready  = 1'b1;
    if (32'(rsp_idx) < NUM_REQS) begin
      core_bus.rsp_valid[rsp_idx] = mem_bus.rsp_valid[0];
      mem_bus.rsp_ready           = core_bus.rsp_ready[rsp_idx];
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [43:0] perf_stalls_q;
  logic [43:0] perf_reqs_q;

  // Stall = some lane requesting but nothing accepted this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_q <= '0;
      perf_reqs_q   <= '0;
    end else begin
      if ((|core_bus.req_valid) && !push) begin
        perf_stalls_q <= perf_stalls_q + 44'd1;
      end
      if (pop) begin
        perf_reqs_q <= perf_reqs_q + 44'd1;
      end
    end
  end

  assign perf_stalls = perf_stalls_q;
  assign perf_reqs   = perf_reqs_q;
`endif

endmodule

// File: tb/tb_vx_core_mem_arb.sv
module tb_vx_core_mem_arb;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  vx_core_mem_arb_if #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(8))  core_bus ();
  vx_core_mem_arb_if #(.N(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(10)) mem_bus ();

`ifdef MEM_ARB_PERF_EN
  logic [43:0] perf_stalls;
  logic [43:0] perf_reqs;
`endif

  vx_core_mem_arb #(
    .NUM_REQS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .core_bus (core_bus),
    .mem_bus  (mem_bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_reqs   (perf_reqs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i: addr 0x100+i, data 0xD000+i, tag 0x10+i
  task automatic init_payload();
    for (int i = 0; i < 4; i++) begin
      core_bus.req_addr[i*32 +: 32] = 32'h100 + 32'(i);
      core_bus.req_data[i*32 +: 32] = 32'hD000 + 32'(i);
      core_bus.req_byteen[i*4 +: 4] = 4'hF;
      core_bus.req_tag[i*8 +: 8]    = 8'h10 + 8'(i);
      core_bus.req_rw[i]            = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    core_bus.req_valid = '0;
    mem_bus.req_ready  = 1'b0;
    init_payload();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset              = 1'b1;
    core_bus.req_valid = 4'b1111;
    mem_bus.req_ready  = 1'b1;
    mem_bus.rsp_valid  = 1'b1;
    mem_bus.rsp_tag    = 10'h233;
    core_bus.rsp_ready = 4'b0100;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready: got %b expected %b", core_bus.req_ready, 4'b0000);
    end
    checks++;
    if (core_bus.rsp_valid !== 4'b0100) begin
      failures++;
      $display("FAIL reset_rsp_route: got %b expected %b", core_bus.rsp_valid, 4'b0100);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_valid: got %b expected 0", mem_bus.req_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_valid_hold: got %b expected 0", mem_bus.req_valid);
    end
    mem_bus.rsp_valid  = 1'b0;
    core_bus.rsp_ready = '0;
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    logic [9:0] exp_tag;
    do_reset();
    mem_bus.req_ready  = 1'b1;
    core_bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_idx = 2'(n % 4);
      exp_tag = {exp_idx, 8'h10 + 8'(exp_idx)};
      #1;
      checks++;
      if (core_bus.req_ready !== 4'(1 << exp_idx)) begin
        failures++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", n, core_bus.req_ready, 4'(1 << exp_idx));
      end
      @(posedge clk); #1;
      checks++;
      if (mem_bus.req_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_mem_valid[%0d]: got %b expected 1", n, mem_bus.req_valid);
      end
      checks++;
      if (mem_bus.req_tag !== exp_tag) begin
        failures++;
        $display("FAIL rr_mem_tag[%0d]: got %h expected %h", n, mem_bus.req_tag, exp_tag);
      end
      @(negedge clk);
    end
    core_bus.req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain_valid: got %b expected 0", mem_bus.req_valid);
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_ready [3];
    logic [9:0] exp_tag   [3];
    exp_ready[0] = 4'b0001; exp_tag[0] = 10'h010;
    exp_ready[1] = 4'b0100; exp_tag[1] = 10'h212;
    exp_ready[2] = 4'b0001; exp_tag[2] = 10'h010;
    do_reset();
    mem_bus.req_ready  = 1'b1;
    core_bus.req_valid = 4'b0101;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (core_bus.req_ready !== exp_ready[n]) begin
        failures++;
        $display("FAIL sparse_ready[%0d]: got %b expected %b", n, core_bus.req_ready, exp_ready[n]);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_bus.req_tag !== exp_tag[n] || mem_bus.req_valid !== 1'b1) begin
        failures++;
        $display("FAIL sparse_tag[%0d]: got v=%b %h expected v=1 %h", n, mem_bus.req_valid, mem_bus.req_tag, exp_tag[n]);
      end
      @(negedge clk);
    end
    core_bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    core_bus.req_tag[8 +: 8] = 8'h21;
    core_bus.req_valid       = 4'b0010;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_ready_first: got %b expected %b", core_bus.req_ready, 4'b0010);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b1 || mem_bus.req_tag !== 10'h121) begin
      failures++;
      $display("FAIL bp_head_first: got v=%b %h expected v=1 121", mem_bus.req_valid, mem_bus.req_tag);
    end
    @(negedge clk);
    core_bus.req_tag[8 +: 8] = 8'h22;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_ready_second: got %b expected %b", core_bus.req_ready, 4'b0010);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_tag !== 10'h121) begin
      failures++;
      $display("FAIL bp_head_hold1: got %h expected 121", mem_bus.req_tag);
    end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); #1;
      checks++;
      if (core_bus.req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready_full[%0d]: got %b expected 0000", n, core_bus.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_bus.req_tag !== 10'h121 || mem_bus.req_addr !== 32'h101 || mem_bus.req_data !== 32'hD001) begin
        failures++;
        $display("FAIL bp_stable[%0d]: got %h/%h/%h expected 121/00000101/0000d001",
                 n, mem_bus.req_tag, mem_bus.req_addr, mem_bus.req_data);
      end
    end
    @(negedge clk);
    core_bus.req_valid = '0;
    mem_bus.req_ready  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b1 || mem_bus.req_tag !== 10'h122) begin
      failures++;
      $display("FAIL bp_drain_second: got v=%b %h expected v=1 122", mem_bus.req_valid, mem_bus.req_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain_empty: got %b expected 0", mem_bus.req_valid);
    end
  endtask

  task automatic test_response();
    @(negedge clk);
    mem_bus.rsp_valid  = 1'b1;
    mem_bus.rsp_tag    = 10'h3A5;
    mem_bus.rsp_data   = 32'hDEADBEEF;
    core_bus.rsp_ready = 4'b1000;
    #1;
    checks++;
    if (core_bus.rsp_valid !== 4'b1000) begin
      failures++;
      $display("FAIL rsp_valid_3: got %b expected 1000", core_bus.rsp_valid);
    end
    checks++;
    if (core_bus.rsp_tag !== 8'hA5 || core_bus.rsp_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rsp_payload: got %h/%h expected a5/deadbeef", core_bus.rsp_tag, core_bus.rsp_data);
    end
    checks++;
    if (mem_bus.rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rsp_ready_hi: got %b expected 1", mem_bus.rsp_ready);
    end
    core_bus.rsp_ready = 4'b0111;
    #1;
    checks++;
    if (mem_bus.rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rsp_ready_lo: got %b expected 0", mem_bus.rsp_ready);
    end
    mem_bus.rsp_tag = 10'h012;
    #1;
    checks++;
    if (core_bus.rsp_valid !== 4'b0001 || core_bus.rsp_tag !== 8'h12 || mem_bus.rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rsp_route_0: got %b/%h/%b expected 0001/12/1",
               core_bus.rsp_valid, core_bus.rsp_tag, mem_bus.rsp_ready);
    end
    mem_bus.rsp_valid = 1'b0;
    #1;
    checks++;
    if (core_bus.rsp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL rsp_idle: got %b expected 0000", core_bus.rsp_valid);
    end
    core_bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_bus.req_valid = 4'b0110;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rm_ready_1: got %b expected 0010", core_bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (core_bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rm_ready_2: got %b expected 0100", core_bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rm_ready_in_reset: got %b expected 0000", core_bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_flush: got %b expected 0", mem_bus.req_valid);
    end
    @(negedge clk);
    reset              = 1'b0;
    core_bus.req_valid = 4'b1010;
    #1;
    checks++;
    if (core_bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rm_first_grant: got %b expected 0010", core_bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_bus.req_valid !== 1'b1 || mem_bus.req_tag !== 10'h111) begin
      failures++;
      $display("FAIL rm_first_head: got v=%b %h expected v=1 111", mem_bus.req_valid, mem_bus.req_tag);
    end
    @(negedge clk);
    core_bus.req_valid = '0;
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    core_bus.req_valid = 4'b0001;
    repeat (5) @(posedge clk);
    @(negedge clk);
    core_bus.req_valid = '0;
    #1;
    checks++;
    if (perf_reqs !== 44'd0 || perf_stalls !== 44'd3) begin
      failures++;
      $display("FAIL perf_blocked: got reqs=%0d stalls=%0d expected reqs=0 stalls=3", perf_reqs, perf_stalls);
    end
    mem_bus.req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (perf_reqs !== 44'd2 || perf_stalls !== 44'd3) begin
      failures++;
      $display("FAIL perf_drain: got reqs=%0d stalls=%0d expected reqs=2 stalls=3", perf_reqs, perf_stalls);
    end
  endtask
`endif

  initial begin
    checks             = 0;
    failures           = 0;
    reset              = 1'b1;
    core_bus.req_valid = '0;
    core_bus.rsp_ready = '0;
    mem_bus.req_ready  = 1'b0;
    mem_bus.rsp_valid  = 1'b0;
    mem_bus.rsp_data   = '0;
    mem_bus.rsp_tag    = '0;
    init_payload();

    test_reset();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_response();
    test_reset_mid();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
